// File: rtl/machine_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : machine_counter_bank
// Description : Machine counter / inhibit CSR bank. Holds mcycle, minstret,
//               NUM_HPM mhpmcounters (with their high halves), the mhpmevent
//               enable bits and a full-width mcountinhibit. The CSR mux takes
//               rd_data_out whenever addr_hit_out is high.
//
//               Optional feature macro: MCOUNTER_OVF_EN
//                 defined   : sticky per-counter overflow flags at 0x7C0
//                             (write-1-to-clear) and a registered ovf_irq_out.
//                 undefined : no flags, 0x7C0 unmapped, ovf_irq_out tied 0.
//
// Ports       : clk_in            clock, all state on rising edge
//               rst_in            synchronous reset, active-low
//               wr_en_in          CSR write strobe (one cycle per write)
//               csr_addr_in       CSR address for read and write
//               data_wr_in        resolved CSR write data
//               instret_inc_in    one instruction retired this cycle
//               hpm_event_in      bit i: event for mhpmcounter(3+i)
//               rd_data_out       combinational read data, 0 on no hit
//               addr_hit_out      address maps to a register in this bank
//               mcountinhibit_out current mcountinhibit value
//               ovf_irq_out       overflow interrupt request
//
// Revision    : 1.0  initial release
// ============================================================================
module machine_counter_bank #(
    parameter int          NUM_HPM           = 4,
    parameter int          COUNTER_WIDTH     = 64,
    parameter logic [31:0] MCOUNTINHIBIT_RST = 32'h0
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  wr_en_in,
    input  logic [11:0]                           csr_addr_in,
    input  logic [31:0]                           data_wr_in,
    input  logic                                  instret_inc_in,
    input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event_in,
    output logic [31:0]                           rd_data_out,
    output logic                                  addr_hit_out,
    output logic [31:0]                           mcountinhibit_out,
    output logic                                  ovf_irq_out
);

    // Counter slots 0..c_NCNT-1 follow the CSR numbering; slot 1 (time) is a hole.
    localparam int          c_NCNT     = 3 + NUM_HPM;
    localparam int          c_HPM_W    = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam int          c_HW       = COUNTER_WIDTH - 32;
    localparam logic [63:0] c_IMPL64   = (64'd1 << c_NCNT) - 64'd1;
    // Implemented counter bits: 0, 2 and 3..2+NUM_HPM; bit1 is always 0.
    localparam logic [31:0] c_CNT_MASK = c_IMPL64[31:0] & 32'hFFFF_FFFD;
    localparam logic [COUNTER_WIDTH-1:0] c_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

    localparam logic [11:0] c_ADDR_CNT_LO = 12'hB00;
    localparam logic [11:0] c_ADDR_CNT_HI = 12'hB80;
    localparam logic [11:0] c_ADDR_EVT    = 12'h323;
    localparam logic [11:0] c_ADDR_INH    = 12'h320;

    logic [31:0]              r_inh;
    logic [c_HPM_W-1:0]       r_evt;
    logic [COUNTER_WIDTH-1:0] w_cnt [c_NCNT];
    logic                     w_inh_wr;

    assign w_inh_wr          = wr_en_in && (csr_addr_in == c_ADDR_INH);
    assign mcountinhibit_out = r_inh;

`ifdef MCOUNTER_OVF_EN
    logic [c_NCNT-1:0] w_wrap;
`endif

    // ------------------------------------------------------------------
    // Counters. A write to either half suppresses the increment for that
    // cycle; the untouched half keeps its value.
    // ------------------------------------------------------------------
    genvar n;
    generate
        for (n = 0; n < c_NCNT; n++) begin : g_cnt
            if (n == 1) begin : g_time_hole
                assign w_cnt[n] = '0;
`ifdef MCOUNTER_OVF_EN
                assign w_wrap[n] = 1'b0;
`endif
            end else begin : g_counter
                logic [COUNTER_WIDTH-1:0] r_val;
                logic                     w_wr_lo;
                logic                     w_wr_hi;
                logic                     w_inc;

                assign w_wr_lo = wr_en_in && (csr_addr_in == (c_ADDR_CNT_LO + 12'(n)));
                assign w_wr_hi = wr_en_in && (csr_addr_in == (c_ADDR_CNT_HI + 12'(n)));

                if (n == 0) begin : g_inc_cycle
                    assign w_inc = ~r_inh[0];
                end else if (n == 2) begin : g_inc_instret
                    assign w_inc = instret_inc_in && ~r_inh[2];
                end else begin : g_inc_hpm
                    assign w_inc = hpm_event_in[n-3] && r_evt[n-3] && ~r_inh[n];
                end

                always_ff @(posedge clk_in) begin
                    if (!rst_in) begin
                        r_val <= '0;
                    end else if (w_wr_lo) begin
                        r_val <= {r_val[COUNTER_WIDTH-1:32], data_wr_in};
                    end else if (w_wr_hi) begin
                        r_val <= {data_wr_in[c_HW-1:0], r_val[31:0]};
                    end else if (w_inc) begin
                        r_val <= r_val + c_ONE;
                    end
                end

                assign w_cnt[n] = r_val;
`ifdef MCOUNTER_OVF_EN
                // Only a genuine increment out of all-ones counts as a wrap.
                assign w_wrap[n] = w_inc && !w_wr_lo && !w_wr_hi && (&r_val);
`endif
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // mcountinhibit and mhpmevent enables
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_inh <= MCOUNTINHIBIT_RST & c_CNT_MASK;
        end else if (w_inh_wr) begin
            r_inh <= data_wr_in & c_CNT_MASK;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_evt <= '0;
        end else begin
            for (int i = 0; i < NUM_HPM; i++) begin
                if (wr_en_in && (csr_addr_in == (c_ADDR_EVT + 12'(i)))) begin
                    r_evt[i] <= data_wr_in[0];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Overflow flags and interrupt
    // ------------------------------------------------------------------
`ifdef MCOUNTER_OVF_EN
    logic [31:0] r_ovf;
    logic        r_irq;
    logic [31:0] w_ovf_nxt;
    logic [31:0] w_ovf_clr;
    logic [31:0] w_irq_mask;

    assign w_ovf_clr = (wr_en_in && (csr_addr_in == 12'h7C0)) ? data_wr_in : 32'h0;
    // Clear first, then OR in new wraps so a same-cycle set survives the clear.
    assign w_ovf_nxt = ((r_ovf & ~w_ovf_clr) | 32'(w_wrap)) & c_CNT_MASK;

    always_comb begin
        w_irq_mask = 32'h5;
        for (int i = 0; i < NUM_HPM; i++) begin
            w_irq_mask[3+i] = r_evt[i];
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_ovf <= '0;
            r_irq <= 1'b0;
        end else begin
            r_ovf <= w_ovf_nxt;
            r_irq <= |(w_ovf_nxt & w_irq_mask);
        end
    end

    assign ovf_irq_out = r_irq;
`else
    assign ovf_irq_out = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Combinational read mux
    // ------------------------------------------------------------------
    always_comb begin
        rd_data_out  = 32'h0;
        addr_hit_out = 1'b0;
        for (int i = 0; i < c_NCNT; i++) begin
            if ((i != 1) && (csr_addr_in == (c_ADDR_CNT_LO + 12'(i)))) begin
                addr_hit_out = 1'b1;
                rd_data_out  = w_cnt[i][31:0];
            end
            if ((i != 1) && (csr_addr_in == (c_ADDR_CNT_HI + 12'(i)))) begin
                addr_hit_out = 1'b1;
                rd_data_out  = 32'(w_cnt[i] >> 32);
            end
        end
        for (int i = 0; i < NUM_HPM; i++) begin
            if (csr_addr_in == (c_ADDR_EVT + 12'(i))) begin
                addr_hit_out = 1'b1;
                rd_data_out  = {31'h0, r_evt[i]};
            end
        end
        if (csr_addr_in == c_ADDR_INH) begin
            addr_hit_out = 1'b1;
            rd_data_out  = r_inh;
        end
`ifdef MCOUNTER_OVF_EN
        if (csr_addr_in == 12'h7C0) begin
            addr_hit_out = 1'b1;
            rd_data_out  = r_ovf;
        end
`endif
    end

endmodule
`default_nettype wire
